// File: rtl/next_pc_register.sv
// Program-counter stage: holds the architectural PC, picks the next PC from
// sequential/branch/jump/register targets and tracks boot/run/halt/fault state.
module next_pc_register #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic        Halt,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] pcPlus4,
  input  logic [31:0] immExt,
  input  logic [25:0] jumpIndex,
  input  logic [31:0] regTarget,
  output logic [31:0] curPC,
  output logic        pcValid,
  output logic        halted,
  output logic        misaligned,
  output logic [31:0] faultPC,
  output logic [31:0] retiredCount
);

  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;

  state_t      state, state_nx;
  logic [31:0] target, pc_nx, fpc_nx, cnt_nx;

  always_comb begin
    target = pcPlus4;
    case (PCSrc)
      2'b00: target = pcPlus4;
      2'b01: target = pcPlus4 + (immExt << 2);
      2'b10: target = {pcPlus4[31:28], jumpIndex, 2'b00};
      2'b11: target = regTarget;
      default: target = pcPlus4;
    endcase
  end

  // Halt outranks the alignment check, so a halt never raises a fault.
  always_comb begin
    state_nx = state;
    pc_nx    = curPC;
    fpc_nx   = faultPC;
    cnt_nx   = retiredCount;
    case (state)
      BOOT: state_nx = RUN;
      RUN: begin
        if (PCWre) begin
          if (Halt) begin
            cnt_nx   = retiredCount + 32'd1;
            state_nx = HALT;
          end else if (target[1:0] != 2'b00) begin
            fpc_nx   = target;
            state_nx = FAULT;
          end else begin
            pc_nx  = target;
            cnt_nx = retiredCount + 32'd1;
          end
        end
      end
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state        <= BOOT;
      curPC        <= RESET_PC;
      faultPC      <= 32'd0;
      retiredCount <= 32'd0;
      pcValid      <= 1'b0;
      halted       <= 1'b0;
      misaligned   <= 1'b0;
    end else begin
      state        <= state_nx;
      curPC        <= pc_nx;
      faultPC      <= fpc_nx;
      retiredCount <= cnt_nx;
      // Status flags are registered copies of the next state, keeping outputs flop-driven.
      pcValid      <= (state_nx == RUN);
      halted       <= (state_nx == HALT);
      misaligned   <= (state_nx == FAULT);
    end
  end

endmodule
